// File: rtl/l1i_pkg.sv
// Shared definitions for the L1 instruction cache: default geometry, line/word widths and FSM states.
package l1i_pkg;
    localparam int FETCH_ADDR_W = 64;
    localparam int OFFSET_W     = 6;
    localparam int INDEX_W      = 6;
    localparam int NUM_WAYS     = 4;
    localparam int BUNDLE_WORDS = 4;
    localparam int PID_W        = 20;
    localparam int TID_W        = 16;
    localparam int ICNT_W       = 64;
    localparam int LINE_W       = 512;
    localparam int WORD_W       = 32;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MISS      = 2'd1,
        ST_WAIT_FILL = 2'd2,
        ST_REPLAY    = 2'd3
    } l1i_state_t;
endpackage

// File: rtl/l1i_victim_select.sv
// Fill-way choice: way already holding the line, else lowest invalid way, else round-robin pointer.
// Purely combinational; o_useRr flags a true eviction so the caller can advance the pointer.
module l1i_victim_select
    import l1i_pkg::*;
#(
    parameter int numWays = NUM_WAYS,
    parameter int WAYW    = 2
) (
    input  logic [numWays-1:0] i_match,
    input  logic [numWays-1:0] i_valid,
    input  logic [WAYW-1:0]    i_rrPtr,
    output logic [WAYW-1:0]    o_way,
    output logic               o_useRr
);
    always_comb begin
        o_way   = i_rrPtr;
        o_useRr = 1'b1;
        // Descending scans so the lowest-numbered candidate is the one that sticks.
        for (int w = numWays - 1; w >= 0; w--) begin
            if (!i_valid[w]) begin
                o_way   = WAYW'(w);
                o_useRr = 1'b0;
            end
        end
        for (int w = numWays - 1; w >= 0; w--) begin
            if (i_match[w]) begin
                o_way   = WAYW'(w);
                o_useRr = 1'b0;
            end
        end
    end
endmodule

// File: rtl/l1i_assoc_cache.sv
// Pid-tagged set-associative L1I with one-cycle registered bundle output and a miss/fill/replay FSM.
// fetchStall_i freezes the bundle outputs and blocks acceptance; a fill always preempts a fetch.
module l1i_assoc_cache
    import l1i_pkg::*;
#(
    parameter int fetchingAddressWidth    = FETCH_ADDR_W,
    parameter int offsetWidth             = OFFSET_W,
    parameter int indexWidth              = INDEX_W,
    parameter int numWays                 = NUM_WAYS,
    parameter int bundleWords             = BUNDLE_WORDS,
    parameter int PidSize                 = PID_W,
    parameter int TidSize                 = TID_W,
    parameter int instructionCounterWidth = ICNT_W
) (
    input  logic                               clock_i,
    input  logic                               cacheReset_i,
    input  logic                               fetchEnable_i,
    input  logic                               fetchStall_i,
    input  logic [fetchingAddressWidth-1:0]    fetchAddress_i,
    input  logic [PidSize-1:0]                 Pid_i,
    input  logic [TidSize-1:0]                 Tid_i,
    input  logic                               cacheUpdate_i,
    input  logic [fetchingAddressWidth-1:0]    cacheUpdateAddress_i,
    input  logic [PidSize-1:0]                 cacheUpdatePid_i,
    input  logic [LINE_W-1:0]                  cacheUpdateLine_i,
    input  logic                               invalidateAll_i,
    output logic                               outputEnable_o,
    output logic [bundleWords*WORD_W-1:0]      outputBundle_o,
    output logic [fetchingAddressWidth-1:0]    bundleAddress_o,
    output logic [2:0]                         bundleLen_o,
    output logic [PidSize-1:0]                 bundlePid_o,
    output logic [TidSize-1:0]                 bundleTid_o,
    output logic [instructionCounterWidth-1:0] bundleStartMajId_o,
    output logic                               cacheMiss_o,
    output logic [fetchingAddressWidth-1:0]    missedAddress_o,
    output logic [PidSize-1:0]                 missedPid_o,
    output logic [TidSize-1:0]                 missedTid_o,
    output logic [instructionCounterWidth-1:0] missedInstMajorId_o,
    output logic                               busy_o
);
    localparam int TAG_W      = fetchingAddressWidth - offsetWidth - indexWidth;
    localparam int SETS       = 1 << indexWidth;
    localparam int WOFF_W     = offsetWidth - 2;
    localparam int LINE_WORDS = 1 << WOFF_W;
    localparam int WAYW       = (numWays > 1) ? $clog2(numWays) : 1;
    localparam int LADDR_W    = fetchingAddressWidth - offsetWidth;

    logic [LINE_W-1:0]  r_data  [numWays][SETS];
    logic [TAG_W-1:0]   r_tag   [numWays][SETS];
    logic [PidSize-1:0] r_pid   [numWays][SETS];
    logic [numWays-1:0] r_valid [SETS];
    logic [WAYW-1:0]    r_rr    [SETS];

    l1i_state_t                         r_state, w_next;
    logic [fetchingAddressWidth-1:0]    r_missAddr;
    logic [PidSize-1:0]                 r_missPid;
    logic [TidSize-1:0]                 r_missTid;
    logic [instructionCounterWidth-1:0] r_majId;

    logic                               r_outEn;
    logic [bundleWords*WORD_W-1:0]      r_bundle;
    logic [fetchingAddressWidth-1:0]    r_bAddr;
    logic [2:0]                         r_bLen;
    logic [PidSize-1:0]                 r_bPid;
    logic [TidSize-1:0]                 r_bTid;
    logic [instructionCounterWidth-1:0] r_bMaj;

    logic [fetchingAddressWidth-1:0] w_lkAddr;
    logic [PidSize-1:0]              w_lkPid;
    logic [TidSize-1:0]              w_lkTid;
    logic [indexWidth-1:0]           w_lkIdx;
    logic [TAG_W-1:0]                w_lkTag;
    logic [WOFF_W-1:0]               w_lkWord;
    logic [numWays-1:0]              w_hitVec;
    logic                            w_hit;
    logic [LINE_W-1:0]               w_hitLine;
    logic [WOFF_W:0]                 w_rem;
    logic [2:0]                      w_len;
    logic [bundleWords*WORD_W-1:0]   w_bundle;
    logic                            w_accept, w_fillMatch, w_replayGo, w_present;
    logic [indexWidth-1:0]           w_fIdx;
    logic [TAG_W-1:0]                w_fTag;
    logic [numWays-1:0]              w_fMatch;
    logic [WAYW-1:0]                 w_vWay;
    logic                            w_useRr;
    logic                            w_unusedFillOffset;

    // REPLAY re-uses the lookup port with the captured miss request.
    assign w_lkAddr = (r_state == ST_REPLAY) ? r_missAddr : fetchAddress_i;
    assign w_lkPid  = (r_state == ST_REPLAY) ? r_missPid  : Pid_i;
    assign w_lkTid  = (r_state == ST_REPLAY) ? r_missTid  : Tid_i;
    assign w_lkIdx  = w_lkAddr[offsetWidth +: indexWidth];
    assign w_lkTag  = w_lkAddr[offsetWidth + indexWidth +: TAG_W];
    assign w_lkWord = w_lkAddr[2 +: WOFF_W];
    assign w_hit    = |w_hitVec;

    always_comb begin
        w_hitVec  = '0;
        w_hitLine = '0;
        for (int w = 0; w < numWays; w++) begin
            w_hitVec[w] = r_valid[w_lkIdx][w] && (r_tag[w][w_lkIdx] == w_lkTag)
                          && (r_pid[w][w_lkIdx] == w_lkPid);
            if (w_hitVec[w]) w_hitLine = r_data[w][w_lkIdx];
        end
    end

    always_comb begin
        w_rem    = (WOFF_W + 1)'(LINE_WORDS) - {1'b0, w_lkWord};
        w_len    = (w_rem < (WOFF_W + 1)'(bundleWords)) ? w_rem[2:0] : 3'(bundleWords);
        w_bundle = '0;
        for (int i = 0; i < bundleWords; i++) begin
            if (i < int'(w_len))
                w_bundle[i*WORD_W +: WORD_W] = w_hitLine[(int'(w_lkWord) + i)*WORD_W +: WORD_W];
        end
    end

    assign busy_o      = (r_state != ST_IDLE) || fetchStall_i || cacheUpdate_i;
    assign w_accept    = fetchEnable_i && !busy_o && !invalidateAll_i;
    assign w_fillMatch = cacheUpdate_i && (cacheUpdatePid_i == r_missPid)
                         && (cacheUpdateAddress_i[offsetWidth +: LADDR_W] == r_missAddr[offsetWidth +: LADDR_W]);
    assign w_replayGo  = (r_state == ST_REPLAY) && !fetchStall_i && !cacheUpdate_i && !invalidateAll_i;
    assign w_present   = (w_accept || w_replayGo) && w_hit;

    always_ff @(posedge clock_i or posedge cacheReset_i) begin
        if (cacheReset_i) r_state <= ST_IDLE;
        else              r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        cacheMiss_o = 1'b0;
        case (r_state)
            ST_IDLE:      if (w_accept && !w_hit) w_next = ST_MISS;
            ST_MISS: begin
                cacheMiss_o = 1'b1;
                w_next      = w_fillMatch ? ST_REPLAY : ST_WAIT_FILL;
            end
            ST_WAIT_FILL: if (w_fillMatch) w_next = ST_REPLAY;
            ST_REPLAY:    if (w_replayGo) w_next = w_hit ? ST_IDLE : ST_MISS;
            default:      w_next = ST_IDLE;
        endcase
        if (invalidateAll_i) w_next = ST_IDLE;
    end

    assign w_fIdx             = cacheUpdateAddress_i[offsetWidth +: indexWidth];
    assign w_fTag             = cacheUpdateAddress_i[offsetWidth + indexWidth +: TAG_W];
    assign w_unusedFillOffset = ^cacheUpdateAddress_i[offsetWidth-1:0];

    always_comb begin
        w_fMatch = '0;
        for (int w = 0; w < numWays; w++)
            w_fMatch[w] = r_valid[w_fIdx][w] && (r_tag[w][w_fIdx] == w_fTag)
                          && (r_pid[w][w_fIdx] == cacheUpdatePid_i);
    end

    l1i_victim_select #(.numWays(numWays), .WAYW(WAYW)) u_victim (
        .i_match (w_fMatch),
        .i_valid (r_valid[w_fIdx]),
        .i_rrPtr (r_rr[w_fIdx]),
        .o_way   (w_vWay),
        .o_useRr (w_useRr)
    );

    always_ff @(posedge clock_i) begin
        if (cacheUpdate_i) begin
            r_data[w_vWay][w_fIdx] <= cacheUpdateLine_i;
            r_tag[w_vWay][w_fIdx]  <= w_fTag;
            r_pid[w_vWay][w_fIdx]  <= cacheUpdatePid_i;
        end
    end

    always_ff @(posedge clock_i or posedge cacheReset_i) begin
        if (cacheReset_i) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else if (invalidateAll_i) begin
            for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
        end else if (cacheUpdate_i) begin
            r_valid[w_fIdx][w_vWay] <= 1'b1;
            if (w_useRr)
                r_rr[w_fIdx] <= (r_rr[w_fIdx] == WAYW'(numWays - 1)) ? '0 : r_rr[w_fIdx] + 1'b1;
        end
    end

    always_ff @(posedge clock_i or posedge cacheReset_i) begin
        if (cacheReset_i) begin
            r_missAddr <= '0;
            r_missPid  <= '0;
            r_missTid  <= '0;
            r_majId    <= '0;
            r_outEn    <= 1'b0;
            r_bundle   <= '0;
            r_bAddr    <= '0;
            r_bLen     <= '0;
            r_bPid     <= '0;
            r_bTid     <= '0;
            r_bMaj     <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_accept && !w_hit) begin
                r_missAddr <= fetchAddress_i;
                r_missPid  <= Pid_i;
                r_missTid  <= Tid_i;
            end
            if (!fetchStall_i) begin
                r_outEn <= w_present;
                if (w_present) begin
                    r_bundle <= w_bundle;
                    r_bAddr  <= w_lkAddr;
                    r_bLen   <= w_len;
                    r_bPid   <= w_lkPid;
                    r_bTid   <= w_lkTid;
                    r_bMaj   <= r_majId;
                    r_majId  <= r_majId + instructionCounterWidth'(w_len);
                end
            end
        end
    end

    assign outputEnable_o      = r_outEn;
    assign outputBundle_o      = r_bundle;
    assign bundleAddress_o     = r_bAddr;
    assign bundleLen_o         = r_bLen;
    assign bundlePid_o         = r_bPid;
    assign bundleTid_o         = r_bTid;
    assign bundleStartMajId_o  = r_bMaj;
    assign missedAddress_o     = {r_missAddr[fetchingAddressWidth-1:offsetWidth], offsetWidth'(0)};
    assign missedPid_o         = r_missPid;
    assign missedTid_o         = r_missTid;
    assign missedInstMajorId_o = r_majId;
endmodule

// File: tb/tb_l1i_assoc_cache.sv
// Directed bench for l1i_assoc_cache: hits, bundle trimming, stall hold, miss/fill/replay, eviction, Pid, reset.
module tb_l1i_assoc_cache;
    logic         clk;
    logic         rst;
    logic         fetchEnable, fetchStall, cacheUpdate, invalidateAll;
    logic [63:0]  fetchAddress, cacheUpdateAddress;
    logic [19:0]  pid, cacheUpdatePid;
    logic [15:0]  tid;
    logic [511:0] cacheUpdateLine;

    logic         outputEnable, cacheMiss, busy;
    logic [127:0] outputBundle;
    logic [63:0]  bundleAddress, missedAddress, bundleStartMajId, missedInstMajorId;
    logic [2:0]   bundleLen;
    logic [19:0]  bundlePid, missedPid;
    logic [15:0]  bundleTid, missedTid;

    int errors = 0;
    int checks = 0;

    l1i_assoc_cache dut (
        .clock_i              (clk),
        .cacheReset_i         (rst),
        .fetchEnable_i        (fetchEnable),
        .fetchStall_i         (fetchStall),
        .fetchAddress_i       (fetchAddress),
        .Pid_i                (pid),
        .Tid_i                (tid),
        .cacheUpdate_i        (cacheUpdate),
        .cacheUpdateAddress_i (cacheUpdateAddress),
        .cacheUpdatePid_i     (cacheUpdatePid),
        .cacheUpdateLine_i    (cacheUpdateLine),
        .invalidateAll_i      (invalidateAll),
        .outputEnable_o       (outputEnable),
        .outputBundle_o       (outputBundle),
        .bundleAddress_o      (bundleAddress),
        .bundleLen_o          (bundleLen),
        .bundlePid_o          (bundlePid),
        .bundleTid_o          (bundleTid),
        .bundleStartMajId_o   (bundleStartMajId),
        .cacheMiss_o          (cacheMiss),
        .missedAddress_o      (missedAddress),
        .missedPid_o          (missedPid),
        .missedTid_o          (missedTid),
        .missedInstMajorId_o  (missedInstMajorId),
        .busy_o               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [511:0] mkline(input logic [31:0] base);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[k*32 +: 32] = base + 32'(k);
        return l;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [63:0] a, input logic [19:0] p, input logic [31:0] base);
        cacheUpdate        = 1'b1;
        cacheUpdateAddress = a;
        cacheUpdatePid     = p;
        cacheUpdateLine    = mkline(base);
        tick();
        cacheUpdate        = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a, input logic [19:0] p, input logic [15:0] t);
        fetchEnable  = 1'b1;
        fetchAddress = a;
        pid          = p;
        tid          = t;
        tick();
        fetchEnable  = 1'b0;
    endtask

    initial begin
        rst = 1'b1; fetchEnable = 1'b0; fetchStall = 1'b0; cacheUpdate = 1'b0; invalidateAll = 1'b0;
        fetchAddress = '0; cacheUpdateAddress = '0; pid = '0; tid = '0; cacheUpdatePid = '0;
        cacheUpdateLine = '0;
        #12;
        check("rst_oe",   outputEnable, 0);
        check("rst_miss", cacheMiss, 0);
        check("rst_busy", busy, 0);
        check("rst_maj",  bundleStartMajId, 0);
        check("rst_len",  bundleLen, 0);
        tick();
        rst = 1'b0;

        // Fill line 0x0 with a competing fetch in the same cycle.
        cacheUpdate = 1'b1; cacheUpdateAddress = 64'h0; cacheUpdatePid = 20'h0;
        cacheUpdateLine = mkline(32'h1000_0000);
        fetchEnable = 1'b1; fetchAddress = 64'h0; pid = 20'h0; tid = 16'h0;
        #1;
        check("fill_busy", busy, 1);
        tick();
        cacheUpdate = 1'b0; fetchEnable = 1'b0;
        check("fill_prio_oe",   outputEnable, 0);
        check("fill_prio_miss", cacheMiss, 0);

        fetch(64'h0, 20'h0, 16'h5);
        check("hit0_oe",     outputEnable, 1);
        check("hit0_len",    bundleLen, 4);
        check("hit0_maj",    bundleStartMajId, 0);
        check("hit0_bundle", outputBundle, 128'h10000003_10000002_10000001_10000000);
        check("hit0_addr",   bundleAddress, 64'h0);
        check("hit0_tid",    bundleTid, 16'h5);
        check("hit0_pid",    bundlePid, 20'h0);
        tick();
        check("hit0_pulse",  outputEnable, 0);

        fetch(64'h10, 20'h0, 16'h5);
        check("hit10_maj",    bundleStartMajId, 4);
        check("hit10_len",    bundleLen, 4);
        check("hit10_bundle", outputBundle, 128'h10000007_10000006_10000005_10000004);

        fetch(64'h38, 20'h0, 16'h5);
        check("hit38_len",    bundleLen, 2);
        check("hit38_maj",    bundleStartMajId, 8);
        check("hit38_bundle", outputBundle, 128'h00000000_00000000_1000000f_1000000e);

        // Stall holds the presented bundle and blocks a new fetch.
        fetchStall = 1'b1; fetchEnable = 1'b1; fetchAddress = 64'h0;
        tick();
        check("stall_oe",   outputEnable, 1);
        check("stall_len",  bundleLen, 2);
        check("stall_busy", busy, 1);
        fetchStall = 1'b0; fetchEnable = 1'b0;
        tick();
        check("unstall_oe", outputEnable, 0);

        fetch(64'h1008, 20'h0, 16'h7);
        check("miss_pulse", cacheMiss, 1);
        check("miss_addr",  missedAddress, 64'h1000);
        check("miss_tid",   missedTid, 16'h7);
        check("miss_maj",   missedInstMajorId, 10);
        check("miss_busy",  busy, 1);
        check("miss_oe",    outputEnable, 0);
        tick();
        check("miss_once",  cacheMiss, 0);
        fill(64'h2000, 20'h0, 32'h3000_0000);
        check("nomatch_oe",   outputEnable, 0);
        check("nomatch_busy", busy, 1);
        fill(64'h1000, 20'h0, 32'h2000_0000);
        check("fill_replay_oe", outputEnable, 0);
        tick();
        check("replay_oe",     outputEnable, 1);
        check("replay_addr",   bundleAddress, 64'h1008);
        check("replay_bundle", outputBundle, 128'h20000005_20000004_20000003_20000002);
        check("replay_maj",    bundleStartMajId, 10);
        check("replay_tid",    bundleTid, 16'h7);

        fetch(64'h0, 20'h1, 16'h0);
        check("pid_miss", cacheMiss, 1);
        tick();
        invalidateAll = 1'b1;
        tick();
        invalidateAll = 1'b0;
        check("inval_busy", busy, 0);
        check("inval_miss", cacheMiss, 0);
        fetch(64'h10, 20'h0, 16'h0);
        check("inval_line_miss", cacheMiss, 1);
        tick();
        invalidateAll = 1'b1;
        tick();
        invalidateAll = 1'b0;

        // Five tags into set 0: the fifth evicts way 0.
        fill(64'h0000, 20'h0, 32'h4000_0000);
        fill(64'h1000, 20'h0, 32'h4100_0000);
        fill(64'h2000, 20'h0, 32'h4200_0000);
        fill(64'h3000, 20'h0, 32'h4300_0000);
        fill(64'h4000, 20'h0, 32'h4400_0000);
        fetch(64'h1000, 20'h0, 16'h0);
        check("ev_hit1_bundle", outputBundle, 128'h41000003_41000002_41000001_41000000);
        check("ev_hit1_maj",    bundleStartMajId, 14);
        fetch(64'h4000, 20'h0, 16'h0);
        check("ev_hit4_bundle", outputBundle, 128'h44000003_44000002_44000001_44000000);
        check("ev_hit4_maj",    bundleStartMajId, 18);
        fetch(64'h0, 20'h0, 16'h0);
        check("ev_tag0_miss", cacheMiss, 1);
        check("ev_miss_maj",  missedInstMajorId, 22);
        tick();
        fill(64'h0, 20'h0, 32'h4500_0000);
        tick();
        check("ev_refill_oe",     outputEnable, 1);
        check("ev_refill_bundle", outputBundle, 128'h45000003_45000002_45000001_45000000);
        check("ev_refill_maj",    bundleStartMajId, 22);
        fetch(64'h1000, 20'h0, 16'h0);
        check("rr_evict_miss", cacheMiss, 1);
        tick();

        // Reset in WAIT_FILL.
        rst = 1'b1;
        #1;
        check("wrst_oe",    outputEnable, 0);
        check("wrst_busy",  busy, 0);
        check("wrst_miss",  cacheMiss, 0);
        check("wrst_maj",   bundleStartMajId, 0);
        check("wrst_len",   bundleLen, 0);
        check("wrst_maddr", missedAddress, 0);
        check("wrst_bndl",  outputBundle, 0);
        tick();
        rst = 1'b0;
        fetch(64'h2000, 20'h0, 16'h0);
        check("post_rst_miss", cacheMiss, 1);
        tick();
        fill(64'h2000, 20'h0, 32'h4600_0000);
        tick();
        check("post_rst_oe",     outputEnable, 1);
        check("post_rst_maj",    bundleStartMajId, 0);
        check("post_rst_bundle", outputBundle, 128'h46000003_46000002_46000001_46000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
